// File: rtl/rbcp_initiator_if.sv
// Request, write-data, read-data and RBCP register-bus signals of the local RBCP initiator.
// master is the initiator's view; slave is the requester/responder side.
interface rbcp_initiator_if #(
  parameter int ABUSWIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ABUSWIDTH-1:0] req_addr;
  logic [7:0]           req_len;
  logic [7:0]           wdata;
  logic                 wdata_valid;
  logic                 wdata_ready;
  logic [7:0]           rdata;
  logic                 rdata_valid;
  logic                 done;
  logic                 err;
  logic                 busy;
  logic                 rbcp_act;
  logic [ABUSWIDTH-1:0] rbcp_addr;
  logic [7:0]           rbcp_wd;
  logic                 rbcp_we;
  logic                 rbcp_re;
  logic                 rbcp_ack;
  logic [7:0]           rbcp_rd;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wdata, wdata_valid, rbcp_ack, rbcp_rd,
    output req_ready, wdata_ready, rdata, rdata_valid, done, err, busy,
           rbcp_act, rbcp_addr, rbcp_wd, rbcp_we, rbcp_re
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wdata, wdata_valid, rbcp_ack, rbcp_rd,
    input  req_ready, wdata_ready, rdata, rdata_valid, done, err, busy,
           rbcp_act, rbcp_addr, rbcp_wd, rbcp_we, rbcp_re
  );
endinterface

// File: rtl/rbcp_initiator.sv
// Local RBCP initiator: splits a burst request into single-byte RBCP strobes,
// auto-incrementing the address and timing out each byte's acknowledge.
module rbcp_initiator #(
  parameter int ABUSWIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic             bus_clk,
  input  logic             bus_rst,
  rbcp_initiator_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT, FIN} state_t;

  state_t               state, next;
  logic [ABUSWIDTH-1:0] addr;
  logic [7:0]           wd, rem, rdata;
  logic                 write, act, rvld;
  logic [15:0]          cnt;
  logic                 timeout, ack_hit;

  always_comb begin
    next    = state;
    timeout = 1'b0;
    ack_hit = 1'b0;
    case (state)
      IDLE:   if (bus.req_valid) begin
                if (bus.req_len == 8'd0) next = FIN;
                else if (bus.req_write)  next = LOAD;
                else                     next = STROBE;
              end
      LOAD:   if (bus.wdata_valid) next = STROBE;
      STROBE: next = WAIT;
      WAIT:   if (bus.rbcp_ack) begin
                ack_hit = 1'b1;
                if (rem == 8'd1) next = FIN;
                else if (write)  next = LOAD;
                else             next = STROBE;
              end else if (cnt == TIMEOUT[15:0]) begin
                timeout = 1'b1;
                next    = IDLE;
              end
      FIN:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state <= IDLE;
      addr  <= '0;
      wd    <= '0;
      rem   <= '0;
      rdata <= '0;
      write <= 1'b0;
      act   <= 1'b0;
      rvld  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= next;
      rvld  <= 1'b0;
      case (state)
        IDLE:   if (bus.req_valid) begin
                  addr  <= bus.req_addr;
                  rem   <= bus.req_len;
                  write <= bus.req_write;
                end
        LOAD:   if (bus.wdata_valid) wd <= bus.wdata;
        STROBE: cnt <= '0;
        WAIT:   if (ack_hit) begin
                  if (!write) begin
                    rdata <= bus.rbcp_rd;
                    rvld  <= 1'b1;
                  end
                  rem <= rem - 8'd1;
                  if (rem != 8'd1) addr <= addr + {{(ABUSWIDTH-1){1'b0}}, 1'b1};
                end else begin
                  cnt <= cnt + 16'd1;
                end
        default: ;
      endcase
      // act spans the whole burst from its first strobe; FIN and timeout end it
      if (next == STROBE)                    act <= 1'b1;
      else if (next == FIN || next == IDLE)  act <= 1'b0;
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.wdata_ready = (state == LOAD);
  assign bus.rbcp_we     = (state == STROBE) &&  write;
  assign bus.rbcp_re     = (state == STROBE) && !write;
  assign bus.done        = (state == FIN);
  assign bus.err         = timeout;
  assign bus.rbcp_act    = act && !timeout;
  assign bus.rbcp_addr   = addr;
  assign bus.rbcp_wd     = wd;
  assign bus.rdata       = rdata;
  assign bus.rdata_valid = rvld;
endmodule

// File: tb/tb_rbcp_initiator.sv
// Directed bench for rbcp_initiator: a responder model ACKs one cycle after each
// strobe (or stays silent on a chosen strobe); a monitor pops expected strobes/bytes.
module tb_rbcp_initiator;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rbcp_initiator_if #(.ABUSWIDTH(32)) ifc();
  logic ack_r = 1'b0;
  logic stray = 1'b0;
  assign ifc.rbcp_ack = ack_r | stray;

  rbcp_initiator #(.ABUSWIDTH(32), .TIMEOUT(TO)) dut (
    .bus_clk (clk),
    .bus_rst (rst),
    .bus     (ifc.master)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wd;
  } strb_t;

  strb_t      exp_s[$];
  logic [7:0] exp_rd[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor state, written only by the monitor process
  int strb_cnt = 0, done_cnt = 0, err_cnt = 0, rvld_cnt = 0, act_cnt = 0, gap_cnt = 0;
  int done_cyc = -1, err_cyc = -1, strb_cyc = -1, first_strb_cyc = -1;
  logic act_at_done = 1'b0, act_at_err = 1'b0, in_burst = 1'b0;

  initial begin
    strb_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ifc.rbcp_re || ifc.rbcp_we) begin
          strb_cnt++;
          strb_cyc = cyc;
          if (!in_burst) first_strb_cyc = cyc;
          in_burst = 1'b1;
          chk("strobe_expected", exp_s.size() != 0, 1);
          if (exp_s.size() != 0) begin
            e = exp_s.pop_front();
            chk("strobe_we", ifc.rbcp_we, e.we);
            chk("strobe_addr", ifc.rbcp_addr, e.addr);
            if (e.we) chk("strobe_wd", ifc.rbcp_wd, e.wd);
          end
        end
        if (ifc.rdata_valid) begin
          rvld_cnt++;
          chk("rdata_expected", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0) chk("rdata", ifc.rdata, exp_rd.pop_front());
        end
        if (ifc.rbcp_act) act_cnt++;
        if (in_burst && ifc.busy && !ifc.rbcp_act && !ifc.done && !ifc.err) gap_cnt++;
        if (ifc.done) begin done_cnt++; done_cyc = cyc; act_at_done = ifc.rbcp_act; in_burst = 1'b0; end
        if (ifc.err)  begin err_cnt++;  err_cyc  = cyc; act_at_err  = ifc.rbcp_act; in_burst = 1'b0; end
        if (!ifc.busy) in_burst = 1'b0;
      end
    end
  end

  // responder: ACK one cycle after each strobe, data = addr[7:0] + 0x90
  int rs_cnt = 0;
  int silent_at = -1;
  initial begin
    int pend;
    logic [7:0] pend_d;
    pend = 0;
    pend_d = 8'h00;
    ifc.rbcp_rd = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      ack_r = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin ack_r = 1'b1; ifc.rbcp_rd = pend_d; end
      end
      if (!rst && (ifc.rbcp_re || ifc.rbcp_we)) begin
        if (rs_cnt != silent_at) begin
          pend = 1;
          pend_d = ifc.rbcp_addr[7:0] + 8'h90;
        end
        rs_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc_wait(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic request(logic w, logic [31:0] a, logic [7:0] l, output int t);
    ifc.req_valid = 1'b1;
    ifc.req_write = w;
    ifc.req_addr  = a;
    ifc.req_len   = l;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      if (ifc.req_ready) begin t = cyc; break; end
      cyc_wait(1);
    end
    chk("req_accepted", t >= 0, 1);
    cyc_wait(1);
    ifc.req_valid = 1'b0;
    ifc.req_write = $urandom_range(0, 1);
    ifc.req_addr  = $urandom();
    ifc.req_len   = $urandom_range(1, 255);
  endtask

  task automatic wait_done(int base, int budget);
    int k;
    k = 0;
    while (done_cnt == base && k < budget) begin cyc_wait(1); k++; end
    chk("done_seen", done_cnt > base, 1);
  endtask

  task automatic wait_err(int base, int budget);
    int k;
    k = 0;
    while (err_cnt == base && k < budget) begin cyc_wait(1); k++; end
    chk("err_seen", err_cnt > base, 1);
  endtask

  task automatic push_rd(logic [31:0] a, logic [7:0] d);
    strb_t s;
    s.we = 1'b0; s.addr = a; s.wd = 8'h00;
    exp_s.push_back(s);
    exp_rd.push_back(d);
  endtask

  initial begin
    int t, hs, d0, e0, s0, a0, sc;
    strb_t s;
    logic [7:0] wv[3];
    wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33;

    ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_addr = '0; ifc.req_len = '0;
    ifc.wdata = '0; ifc.wdata_valid = 1'b0;
    rst = 1'b1;
    cyc_wait(3);
    chk("rst_req_ready", ifc.req_ready, 1);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_act", ifc.rbcp_act, 0);
    chk("rst_strobes", {ifc.rbcp_we, ifc.rbcp_re}, 0);
    chk("rst_outs", {ifc.rbcp_addr, ifc.rbcp_wd, ifc.rdata, ifc.rdata_valid, ifc.done, ifc.err, ifc.wdata_ready}, 0);
    rst = 1'b0;
    cyc_wait(2);

    // stray ACK in IDLE does nothing
    d0 = done_cnt; a0 = rvld_cnt;
    stray = 1'b1; cyc_wait(1); stray = 1'b0; cyc_wait(2);
    chk("stray_ready", ifc.req_ready, 1);
    chk("stray_busy", ifc.busy, 0);
    chk("stray_no_evt", (done_cnt - d0) + (rvld_cnt - a0), 0);

    // read burst 0x10 x4 -> 0xA0..0xA3
    for (int i = 0; i < 4; i++) push_rd(32'h10 + i, 8'hA0 + 8'(i));
    d0 = done_cnt; sc = gap_cnt;
    request(1'b0, 32'h10, 8'd4, t);
    wait_done(d0, 40);
    chk("rd_first_re_cyc", first_strb_cyc, t + 1);
    chk("rd_done_cyc", done_cyc, t + 9);
    chk("rd_act_at_done", act_at_done, 0);
    chk("rd_act_gap", gap_cnt - sc, 0);
    chk("rd_q_empty", exp_s.size() + exp_rd.size(), 0);
    cyc_wait(1);
    chk("rd_ready_after", ifc.req_ready, 1);
    chk("rd_done_once", done_cnt - d0, 1);

    // write burst 0x100 x3 with gapped data
    for (int i = 0; i < 3; i++) begin
      s.we = 1'b1; s.addr = 32'h100 + i; s.wd = wv[i];
      exp_s.push_back(s);
    end
    d0 = done_cnt;
    request(1'b1, 32'h100, 8'd3, t);
    for (int i = 0; i < 3; i++) begin
      sc = strb_cnt;
      cyc_wait(5);
      chk("wr_no_strobe_gap", strb_cnt - sc, 0);
      ifc.wdata = wv[i]; ifc.wdata_valid = 1'b1;
      hs = -1;
      for (int k = 0; k < 20; k++) begin
        if (ifc.wdata_ready) begin hs = cyc; break; end
        cyc_wait(1);
      end
      chk("wr_handshake", hs >= 0, 1);
      cyc_wait(1);
      ifc.wdata_valid = 1'b0;
      ifc.wdata = $urandom_range(0, 255);
      chk("wr_we_cyc", strb_cyc, hs + 1);
    end
    wait_done(d0, 40);
    chk("wr_done_once", done_cnt - d0, 1);
    chk("wr_q_empty", exp_s.size(), 0);
    cyc_wait(1);

    // timeout on byte 2 of 4
    silent_at = rs_cnt + 1;
    push_rd(32'h200, 8'h90);
    s.we = 1'b0; s.addr = 32'h201; s.wd = 8'h00; exp_s.push_back(s);
    d0 = done_cnt; e0 = err_cnt;
    request(1'b0, 32'h200, 8'd4, t);
    wait_err(e0, 40);
    chk("to_strobe2_cyc", strb_cyc, t + 3);
    chk("to_err_cyc", err_cyc, t + 3 + 1 + TO);
    chk("to_act_at_err", act_at_err, 0);
    cyc_wait(1);
    chk("to_ready", ifc.req_ready, 1);
    cyc_wait(3);
    chk("to_err_once", err_cnt - e0, 1);
    chk("to_no_done", done_cnt - d0, 0);
    chk("to_q_empty", exp_s.size() + exp_rd.size(), 0);

    // zero length
    d0 = done_cnt; s0 = strb_cnt; a0 = act_cnt;
    request(1'b0, 32'h40, 8'd0, t);
    wait_done(d0, 10);
    chk("z_done_cyc", done_cyc, t + 1);
    chk("z_no_strobe", strb_cnt - s0, 0);
    chk("z_no_act", act_cnt - a0, 0);
    cyc_wait(1);

    // address wrap
    push_rd(32'hFFFF_FFFE, 8'h8E);
    push_rd(32'hFFFF_FFFF, 8'h8F);
    push_rd(32'h0000_0000, 8'h90);
    d0 = done_cnt;
    request(1'b0, 32'hFFFF_FFFE, 8'd3, t);
    wait_done(d0, 30);
    chk("wrap_done_cyc", done_cyc, t + 7);
    chk("wrap_q_empty", exp_s.size() + exp_rd.size(), 0);
    cyc_wait(1);

    // reset during WAIT of byte 2
    silent_at = rs_cnt + 1;
    push_rd(32'h300, 8'h90);
    s.we = 1'b0; s.addr = 32'h301; s.wd = 8'h00; exp_s.push_back(s);
    d0 = done_cnt; e0 = err_cnt;
    request(1'b0, 32'h300, 8'd4, t);
    cyc_wait(4);
    chk("mr_busy_before", ifc.busy, 1);
    rst = 1'b1;
    #1;
    chk("mr_ready", ifc.req_ready, 1);
    chk("mr_busy", ifc.busy, 0);
    chk("mr_act", ifc.rbcp_act, 0);
    chk("mr_outs", {ifc.rbcp_addr, ifc.rbcp_wd, ifc.rdata, ifc.rdata_valid, ifc.done, ifc.err, ifc.rbcp_we, ifc.rbcp_re}, 0);
    cyc_wait(2);
    rst = 1'b0;
    cyc_wait(12);
    chk("mr_no_done_err", (done_cnt - d0) + (err_cnt - e0), 0);
    chk("mr_q_empty", exp_s.size() + exp_rd.size(), 0);
    push_rd(32'h20, 8'hB0);
    push_rd(32'h21, 8'hB1);
    d0 = done_cnt;
    request(1'b0, 32'h20, 8'd2, t);
    wait_done(d0, 20);
    chk("mr_after_done_cyc", done_cyc, t + 5);
    chk("mr_after_q_empty", exp_s.size() + exp_rd.size(), 0);
    cyc_wait(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
